// File: rtl/pipeline_pkg.sv
// Shared pipeline types: the IF/ID record, the prefetch entry and the fetch NOP.
// Also holds the PC increment helper used by the fetch stage.
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [31:0] instr;
  } ifid_t;

  typedef struct packed {
    logic [31:0] PC;
    logic [31:0] instr;
  } fetch_entry_t;

  // Sequential PC; wraps modulo 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push, pop, flush and occupancy; storage is registered
// and the head is read straight from the storage array (no bypass).
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign push_ok = push_i && !flush_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !flush_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, credit-limited imem requests, prefetch FIFO
// and redirect squashing. Optional perf counters are built when IF_PERF_EN is defined.
module fetch_unit
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [29:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        valid_o,
  input  logic        ready_i,
  output ifid_t       outputs,
  output logic [31:0] PCPlus4F
`ifdef IF_PERF_EN
  ,
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_squashed_o
`endif
);

  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int ICW = $clog2(MAX_OUTSTANDING + 1);

  // Handshakes: an imem request transfers when imem_req_o && imem_gnt_i in the same
  // cycle; a decode transfer happens when valid_o && ready_i. valid_o never depends
  // on ready_i, and imem_rvalid_i is always accepted (no back-pressure).

  logic [31:0]    pc_q, pc_d;
  logic [OW-1:0]  outstanding_q, outstanding_d;
  logic [OW-1:0]  discard_q, discard_d;

  logic           grant, drop, keep, pop;
  logic [31:0]    free_slots, pending;

  logic [63:0]    pf_data;
  logic [FCW-1:0] pf_count;
  logic           pf_full, pf_empty;
  fetch_entry_t   head;

  logic [31:0]    if_pc;
  logic [ICW-1:0] if_count;
  logic           if_full, if_empty;
  logic           unused_status;

  assign unused_status = ^{if_count, if_full, if_empty, pf_full, redirect_pc_i[1:0]};

  // Credit rule: every response not already marked for discard owns a free slot.
  assign free_slots = 32'(FIFO_DEPTH) - 32'(pf_count);
  assign pending    = 32'(outstanding_q) - 32'(discard_q);
  assign imem_req_o = rst_n && !redirect_i
                   && (32'(outstanding_q) < 32'(MAX_OUTSTANDING))
                   && (free_slots > pending);
  assign imem_addr_o = pc_q[31:2];
  assign PCPlus4F    = next_pc(pc_q);

  assign grant = imem_req_o && imem_gnt_i;
  assign drop  = imem_rvalid_i && (redirect_i || (discard_q != '0));
  assign keep  = imem_rvalid_i && !drop;
  assign pop   = valid_o && ready_i && !redirect_i;

  fetch_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (32)
  ) u_inflight_pc (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (grant),
    .data_i  (pc_q),
    .pop_i   (imem_rvalid_i),
    .flush_i (1'b0),
    .data_o  (if_pc),
    .count_o (if_count),
    .full_o  (if_full),
    .empty_o (if_empty)
  );

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_prefetch (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (keep),
    .data_i  ({if_pc, imem_rdata_i}),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .data_o  (pf_data),
    .count_o (pf_count),
    .full_o  (pf_full),
    .empty_o (pf_empty)
  );

  assign head    = fetch_entry_t'(pf_data);
  assign valid_o = !pf_empty;

  always_comb begin
    outputs = '0;
    if (!pf_empty) begin
      outputs.PC      = head.PC;
      outputs.PCPlus4 = next_pc(head.PC);
      outputs.instr   = head.instr;
    end else if (rst_n) begin
      outputs.instr = NOP_INSTR;
    end
  end

  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;

    if (redirect_i) begin
      pc_d = {redirect_pc_i[31:2], 2'b00};
    end else if (grant) begin
      pc_d = next_pc(pc_q);
    end

    case ({grant, imem_rvalid_i})
      2'b10:   outstanding_d = outstanding_q + OW'(1);
      2'b01:   outstanding_d = outstanding_q - OW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    // Everything still in flight after a redirect belongs to the old stream.
    if (redirect_i) begin
      discard_d = outstanding_q - OW'(imem_rvalid_i);
    end else if (drop) begin
      discard_d = discard_q - OW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

`ifdef IF_PERF_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] squashed_q, squashed_d;

  // Flushed FIFO entries count as squashed alongside dropped responses.
  always_comb begin
    fetched_d  = fetched_q + 32'(pop);
    squashed_d = squashed_q + 32'(drop) + (redirect_i ? 32'(pf_count) : 32'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q  <= '0;
      squashed_q <= '0;
    end else begin
      fetched_q  <= fetched_d;
      squashed_q <= squashed_d;
    end
  end

  assign perf_fetched_o  = fetched_q;
  assign perf_squashed_o = squashed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a bench-side imem with configurable latency and
// grant stalls, a transaction model of the fetch stream, and per-cycle scoreboarding.
`timescale 1ns/1ps
module tb_fetch_unit;
  import pipeline_pkg::*;

  localparam logic [31:0] RESET_PC   = 32'h0000_0100;
  localparam int          FIFO_DEPTH = 4;
  localparam int          MAX_OUT    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        valid;
  logic        ready;
  ifid_t       outputs;
  logic [31:0] PCPlus4F;
`ifdef IF_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_squashed;
`endif

  fetch_unit #(
    .RESET_PC        (RESET_PC),
    .FIFO_DEPTH      (FIFO_DEPTH),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_i      (redirect),
    .redirect_pc_i   (redirect_pc),
    .imem_req_o      (imem_req),
    .imem_addr_o     (imem_addr),
    .imem_gnt_i      (imem_gnt),
    .imem_rvalid_i   (imem_rvalid),
    .imem_rdata_i    (imem_rdata),
    .valid_o         (valid),
    .ready_i         (ready),
    .outputs         (outputs),
    .PCPlus4F        (PCPlus4F)
`ifdef IF_PERF_EN
    ,
    .perf_fetched_o  (perf_fetched),
    .perf_squashed_o (perf_squashed)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard and model state
  int          n_cmp = 0;
  int          n_mis = 0;
  int          cyc, out_cnt, disc, occ, last_due;
  int          lat_min, lat_max;
  bit          gnt_rand;
  logic [31:0] fpc;
  logic [31:0] exp_fetched, exp_squashed;
  logic [31:0] exp_q[$];
  logic [29:0] rq_addr[$];
  int          rq_due[$];
  logic [29:0] resp_addr;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a, 2'b00} ^ 32'hC3A5_0001;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Driver: present this cycle's memory response and grant.
  task automatic begin_cycle();
    redirect    = 1'b0;
    redirect_pc = '0;
    if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      resp_addr   = rq_addr.pop_front();
      void'(rq_due.pop_front());
      imem_rdata  = mem_word(resp_addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    imem_gnt = gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Check the settled cycle against the model, then advance model and clock.
  task automatic finish_cycle();
    logic exp_req, grant, drop, kept, pop;
    logic [31:0] head;
    int due;
    exp_req = !redirect && (out_cnt < MAX_OUT) && ((FIFO_DEPTH - occ) > (out_cnt - disc));
    check_eq("req", imem_req, exp_req);
    check_eq("pcplus4f", PCPlus4F, fpc + 32'd4);
    if (exp_req) check_eq("addr", imem_addr, fpc[31:2]);
    check_eq("valid", valid, occ > 0);
    check_eq("outstanding_max", out_cnt <= MAX_OUT, 1'b1);
    pop = valid && ready && !redirect;
    if (pop && exp_q.size() > 0) begin
      head = exp_q[0];
      check_eq("out_pc", outputs.PC, head);
      check_eq("out_pcplus4", outputs.PCPlus4, head + 32'd4);
      check_eq("out_instr", outputs.instr, mem_word(head[31:2]));
    end
    if (!valid) check_eq("idle_instr", outputs.instr, NOP_INSTR);
`ifdef IF_PERF_EN
    check_eq("perf_fetched", perf_fetched, exp_fetched);
    check_eq("perf_squashed", perf_squashed, exp_squashed);
`endif
    grant = imem_req && imem_gnt;
    drop  = imem_rvalid && (redirect || disc > 0);
    kept  = imem_rvalid && !drop;
    if (grant) begin
      due = cyc + int'($urandom_range(lat_min, lat_max));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      rq_addr.push_back(imem_addr);
      rq_due.push_back(due);
    end
    exp_fetched  = exp_fetched + 32'(pop);
    exp_squashed = exp_squashed + 32'(drop) + (redirect ? 32'(occ) : 32'd0);
    if (redirect) begin
      disc = out_cnt - int'(imem_rvalid);
      exp_q.delete();
      fpc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (drop) disc--;
      if (kept) exp_q.push_back({resp_addr, 2'b00});
      if (pop) void'(exp_q.pop_front());
      if (grant) fpc = fpc + 32'd4;
    end
    occ = exp_q.size();
    out_cnt = out_cnt + int'(grant) - int'(imem_rvalid);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      begin_cycle();
      settle();
      finish_cycle();
    end
  endtask

  // Wait (bounded) for the first valid entry and check its PC fields.
  task automatic wait_valid(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_pc4);
    bit found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      begin_cycle();
      settle();
      if (valid) begin
        found = 1;
        check_eq({tag, "_pc"}, outputs.PC, exp_pc);
        check_eq({tag, "_pcplus4"}, outputs.PCPlus4, exp_pc4);
      end
      finish_cycle();
    end
    check_eq({tag, "_seen"}, found, 1'b1);
  endtask

  logic [31:0] dir_q[$];
  int          pops;
  bit          done;
  logic [29:0] wrap_addr[$];

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; ready = 1'b0; resp_addr = '0;
    cyc = 0; out_cnt = 0; disc = 0; occ = 0; last_due = -1;
    lat_min = 1; lat_max = 1; gnt_rand = 0;
    fpc = RESET_PC; exp_fetched = '0; exp_squashed = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_valid", valid, 1'b0);
    check_eq("rst_req", imem_req, 1'b0);
    check_eq("rst_out_pc", outputs.PC, 32'h0);
    check_eq("rst_out_pcplus4", outputs.PCPlus4, 32'h0);
    check_eq("rst_out_instr", outputs.instr, 32'h0);
    check_eq("rst_pcplus4f", PCPlus4F, 32'h104);
`ifdef IF_PERF_EN
    check_eq("rst_perf_fetched", perf_fetched, 32'h0);
    check_eq("rst_perf_squashed", perf_squashed, 32'h0);
`endif

    // First fetches with L=1: PCs 0x100,0x104,0x108 from cycle 2
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    dir_q = '{32'h100, 32'h104, 32'h108};
    for (int i = 0; i < 5; i++) begin
      begin_cycle();
      settle();
      if (i == 0) check_eq("first_addr", imem_addr, 32'h40);
      if (i == 1) check_eq("second_addr", imem_addr, 32'h41);
      check_eq("start_valid", valid, (i >= 2));
      if (i >= 2) check_eq("start_pc", outputs.PC, dir_q.pop_front());
      finish_cycle();
    end

    // Steady state: one instruction per cycle
    run(3);
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      begin_cycle();
      settle();
      if (valid && ready) pops++;
      finish_cycle();
    end
    check_eq("steady_rate", pops, 8);

    // Decode stall fills the FIFO and throttles requests
    ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      begin_cycle();
      settle();
      if (i == 9) begin
        check_eq("stall_req_low", imem_req, 1'b0);
        check_eq("stall_valid", valid, 1'b1);
      end
      finish_cycle();
    end
    ready = 1'b1;
    run(12);

    // Redirect with two requests in flight
    lat_min = 3; lat_max = 3;
    run(8);
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      begin_cycle();
      if (out_cnt == 2 && !imem_rvalid) begin
        redirect = 1'b1;
        redirect_pc = 32'h0000_2000;
        done = 1;
      end
      settle();
      finish_cycle();
    end
    check_eq("redir2_found", done, 1'b1);
    wait_valid("redir2", 32'h0000_2000, 32'h0000_2004);
    run(6);

    // Redirect coinciding with a response and a pop
    lat_min = 1; lat_max = 1;
    run(6);
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      begin_cycle();
      if (imem_rvalid && valid) begin
        redirect = 1'b1;
        redirect_pc = 32'h0000_3000;
        done = 1;
      end
      settle();
      finish_cycle();
    end
    check_eq("redir_pop_found", done, 1'b1);
    begin_cycle();
    settle();
    check_eq("flush_empty", valid, 1'b0);
    finish_cycle();
    wait_valid("redir3", 32'h0000_3000, 32'h0000_3004);

    // Redirect to the top of the address space; low bits ignored
    begin_cycle();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    settle();
    finish_cycle();
    for (int i = 0; i < 20 && wrap_addr.size() < 2; i++) begin
      begin_cycle();
      settle();
      if (i == 0) check_eq("wrap_pcplus4f", PCPlus4F, 32'h0);
      if (imem_req && imem_gnt) wrap_addr.push_back(imem_addr);
      finish_cycle();
    end
    check_eq("wrap_reqs", wrap_addr.size(), 2);
    if (wrap_addr.size() == 2) begin
      check_eq("wrap_addr0", wrap_addr[0], 32'h3FFF_FFFF);
      check_eq("wrap_addr1", wrap_addr[1], 32'h0);
    end
    wait_valid("wrap", 32'hFFFF_FFFC, 32'h0);
    run(4);

    // Random grant stalls, latency 1..4, random ready and occasional redirects
    gnt_rand = 1; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 400; i++) begin
      begin_cycle();
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        redirect = 1'b1;
        redirect_pc = $urandom;
      end
      settle();
      finish_cycle();
    end

    // Drain
    gnt_rand = 0; ready = 1'b1;
    run(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage that replaces the single-cycle combinational fetch path. It owns the PC register and issues word requests to a pipelined instruction memory through a request/grant/response handshake, with a bounded number of requests in flight. Returned instructions are buffered in a prefetch FIFO, and each FIFO entry is presented to decode as an `ifid_t` record with a valid/ready handshake. Control-flow redirects flush the buffer and squash stale in-flight responses.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `FIFO_DEPTH`, default 4: prefetch entries. Must be a power of two and ≥2.
- `MAX_OUTSTANDING`, default 2: maximum imem requests in flight. Must be ≥1 and ≤`FIFO_DEPTH`.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `redirect_i` in 1: taken branch, jump or trap from a later stage.
- `redirect_pc_i` in 32: new fetch PC. Bits [1:0] are ignored.
- `imem_req_o` out 1: request valid.
- `imem_addr_o` out 30: word address, equal to PC[31:2].
- `imem_gnt_i` in 1: request accepted in the same cycle.
- `imem_rvalid_i` in 1: response valid. Responses return in order, at least 1 cycle after the grant.
- `imem_rdata_i` in 32: instruction word.
- `valid_o` out 1: FIFO head valid.
- `ready_i` in 1: decode accepts the head. Deasserted while decode stalls.
- `outputs` out `ifid_t`: fields `PC`, `PCPlus4`, `instr` of the FIFO head.
- `PCPlus4F` out 32: fetch PC + 4, taken from the PC register.
- Present only with `IF_PERF_EN`:
  - `perf_fetched_o` out 32: count of instructions accepted by decode.
  - `perf_squashed_o` out 32: count of discarded responses.

## Operation
- State:
  - `pc_q`: PC register.
  - `outstanding_q`: requests granted but not yet answered, 0..`MAX_OUTSTANDING`.
  - `discard_q`: number of upcoming responses to drop, 0..`MAX_OUTSTANDING`.
  - FIFO of `{PC, instr}` entries.
- Request issue: `imem_req_o` = !`redirect_i` && `outstanding_q` < `MAX_OUTSTANDING` && (FIFO free slots) > (`outstanding_q` − `discard_q`).
  - This credit rule guarantees every kept response has a free FIFO slot.
  - The FIFO never overflows, and `imem_rvalid_i` is never back-pressured.
- On `imem_req_o` && `imem_gnt_i`: `pc_q` += 4 and `outstanding_q` increments.
- The PC of each request is queued alongside it (a small in-flight PC queue of depth `MAX_OUTSTANDING`) and paired with its response.
- On `imem_rvalid_i`: `outstanding_q` decrements.
  - If `discard_q` > 0, the response is dropped and `discard_q` decrements.
  - Otherwise `{pc, imem_rdata_i}` is pushed into the FIFO.
- Pop: a FIFO pop occurs when `valid_o` && `ready_i`.
- Simultaneous push and pop are legal in any occupancy, including full.
- `outputs.PCPlus4` = `outputs.PC` + 4, computed modulo 2^32 (wraps at 32'hFFFF_FFFC).
- Redirect has priority over everything else in its cycle:
  - The FIFO is emptied.
  - `pc_q` ← {`redirect_pc_i`[31:2], 2'b00}.
  - No request is issued.
  - `discard_q` ← `outstanding_q` minus 1 if a response arrives in this cycle (that response is dropped).
  - Any pop in the redirect cycle is ignored.
- Back-to-back redirects: each one reloads the PC, and `discard_q` tracks all remaining stale responses.

## Timing
- Reset values: `pc_q`=`RESET_PC`, `outstanding_q`=0, `discard_q`=0, FIFO empty.
- Outputs under reset: `valid_o`=0, `imem_req_o`=0, `outputs`=0, `PCPlus4F`=`RESET_PC`+4, perf counters 0.
- First request is issued in the first cycle after `rst_n` rises.
- Latency: grant at cycle t with response at t+L gives `valid_o` at t+L+1. The FIFO output is registered, with no bypass.
- Redirect at cycle t: request for the new PC at t+1 at the earliest, or later if `outstanding_q` is saturated.
- Steady state with `MAX_OUTSTANDING` ≥ L+1 and `ready_i`=1: one instruction per cycle.
- Reset asserted mid-transaction: all state clears asynchronously. Responses to pre-reset requests are the memory's responsibility and are not discarded.

## Configuration
- `IF_PERF_EN` defined:
  - Two 32-bit wrapping counters and their ports exist.
  - `perf_fetched_o` increments on each pop.
  - `perf_squashed_o` increments on each dropped response and on each FIFO entry flushed by a redirect (adds the flushed occupancy).
- Undefined: the counters and ports are absent. All other behaviour is identical.

## Structure
- `pipeline_pkg` holds:
  - `ifid_t` (existing).
  - New `fetch_entry_t` {PC, instr}.
  - `localparam` `NOP_INSTR` = 32'h0000_0013, used as `outputs.instr` when the FIFO is empty.
- Sub-module `fetch_fifo`: parametrised synchronous FIFO with push, pop, flush, count, full and empty.
  - It is used for both the prefetch FIFO and the in-flight PC queue.

## Test plan
- Reset `RESET_PC`=32'h100, imem L=1, `ready_i`=1 → requests 0x40, 0x41, …; outputs PC 0x100, 0x104, 0x108 on consecutive cycles starting 3 cycles after reset release.
- `ready_i`=0 for 10 cycles → FIFO fills to `FIFO_DEPTH` and `imem_req_o` drops; no response is lost. On release, PCs continue in sequence without a gap.
- Redirect to 0x2000 with 2 requests outstanding → both stale responses dropped; next `valid_o` shows PC 0x2000; `perf_squashed_o` rises by 2 plus the flushed occupancy.
- Redirect coinciding with response arrival and with a pop → response dropped, no pop counted, FIFO empty the next cycle.
- Redirect to 32'hFFFF_FFFC → `outputs.PCPlus4`=0 and next request address 0.
- Random `imem_gnt_i` stall and latency 1–4 with random `ready_i` → decoded PC stream matches a reference model; `outstanding_q` never exceeds `MAX_OUTSTANDING`.
